// File: rtl/central_unit_pkg.sv
// Shared definitions for the micro_sequencer control stage: opcodes,
// microinstruction field positions and sequencer states.
package central_unit_pkg;

  localparam int CTRL_W      = 21;
  localparam int STACK_DEPTH = 4;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRC  = 3'b011;
  localparam logic [2:0] OP_END  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  // Bit positions inside the 32-bit microinstruction
  localparam int OP_LO     = 29;
  localparam int NXT_LO    = 21;
  localparam int NXT_W     = 8;
  localparam int DATAIN_LO = 17;
  localparam int S_LO      = 13;
  localparam int M_BIT     = 12;
  localparam int PIN_BIT   = 11;
  localparam int ISR_BIT   = 10;
  localparam int ISL_BIT   = 9;
  localparam int A_BIT     = 8;
  localparam int WR_BIT    = 7;
  localparam int ADR_LO    = 4;
  localparam int V_LO      = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/micro_rom.sv
// Writable microprogram store: synchronous write port, combinational read port.
module micro_rom
  import central_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer driving the RALU control word from a writable store.
// Define SUBROUTINE_EN to add CALL/RET with a 4-entry return stack.
module micro_sequencer
  import central_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              Pout,
  input  logic [3:0]        R,
  output logic [3:0]        DataIn,
  output logic [3:0]        S,
  output logic              M,
  output logic              Pin,
  output logic              ISR,
  output logic              ISL,
  output logic              A,
  output logic              wr,
  output logic [2:0]        adr,
  output logic [3:0]        v
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, nxt;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         word;
  logic [2:0]          op;
  logic                rom_we;

`ifdef SUBROUTINE_EN
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]   stack_d [STACK_DEPTH];
  logic [2:0]          sp_q, sp_d;
`endif

  // Program loading is locked out while a microprogram is running
  assign rom_we = prog_we && (state_q == ST_IDLE);

  micro_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clock (clock),
    .we    (rom_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (word)
  );

  assign op     = word[OP_LO +: 3];
  assign nxt    = ADDR_W'(word[NXT_LO +: NXT_W]);
  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SUBROUTINE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      sp_q    <= sp_d;
      stack_q <= stack_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef SUBROUTINE_EN
    sp_d    = sp_q;
    stack_d = stack_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = start_addr;
`ifdef SUBROUTINE_EN
          sp_d    = '0;
`endif
        end
      end
      ST_RUN: begin
        case (op)
          OP_NEXT: pc_d = pc_inc;
          OP_JUMP: pc_d = nxt;
          OP_BRZ:  pc_d = (R == 4'd0) ? nxt : pc_inc;
          OP_BRC:  pc_d = Pout ? nxt : pc_inc;
          OP_END: begin
            state_d = ST_IDLE;
            pc_d    = pc_inc;
          end
`ifdef SUBROUTINE_EN
          OP_CALL: begin
            pc_d = nxt;
            // A full stack still takes the jump; only the return address is lost
            if (sp_q < 3'(STACK_DEPTH)) begin
              stack_d[sp_q[1:0]] = pc_inc;
              sp_d               = sp_q + 3'd1;
            end
          end
          OP_RET: begin
            if (sp_q != 3'd0) begin
              pc_d = stack_q[2'(sp_q - 3'd1)];
              sp_d = sp_q - 3'd1;
            end else begin
              pc_d = pc_inc;
            end
          end
`endif
          default: pc_d = pc_inc;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    done_d = 1'b0;
    busy_d = (state_d == ST_RUN);
    if (state_q == ST_RUN) begin
      ctrl_d = word[CTRL_W-1:0];
      done_d = (op == OP_END);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign DataIn = ctrl_q[DATAIN_LO +: 4];
  assign S      = ctrl_q[S_LO +: 4];
  assign M      = ctrl_q[M_BIT];
  assign Pin    = ctrl_q[PIN_BIT];
  assign ISR    = ctrl_q[ISR_BIT];
  assign ISL    = ctrl_q[ISL_BIT];
  assign A      = ctrl_q[A_BIT];
  assign wr     = ctrl_q[WR_BIT];
  assign adr    = ctrl_q[ADR_LO +: 3];
  assign v      = ctrl_q[V_LO +: 4];

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: per-cycle expected {busy, done, ctrl}
// records are queued before each run and compared as the sequencer issues words.
module tb_micro_sequencer;

  localparam int AW = 5;
  localparam logic [2:0] T_NEXT = 3'b000;
  localparam logic [2:0] T_JUMP = 3'b001;
  localparam logic [2:0] T_BRZ  = 3'b010;
  localparam logic [2:0] T_BRC  = 3'b011;
  localparam logic [2:0] T_END  = 3'b100;
  localparam logic [2:0] T_CALL = 3'b101;
  localparam logic [2:0] T_RET  = 3'b110;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic          Pout = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [3:0]    R = '0;
  logic          busy, done;
  logic [3:0]    DataIn, S;
  logic          M, Pin, ISR, ISL, A, wr;
  logic [2:0]    adr;
  logic [3:0]    v;

  int errors = 0;
  int checks = 0;
  logic [22:0] sbq[$];
  logic [22:0] e;

  micro_sequencer #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .busy(busy), .done(done), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Pout(Pout), .R(R), .DataIn(DataIn), .S(S),
    .M(M), .Pin(Pin), .ISR(ISR), .ISL(ISL), .A(A), .wr(wr), .adr(adr), .v(v)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] obs();
    return {busy, done, DataIn, S, M, Pin, ISR, ISL, A, wr, adr, v};
  endfunction

  function automatic logic [20:0] pat(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] nx,
                                     input logic [20:0] c);
    return {op, nx, c};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] w);
    prog_we = 1'b1; prog_addr = a; prog_data = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (obs() !== 23'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs(), 23'd0);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs() !== 23'd0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs(), 23'd0);
    end
  endtask

  task automatic test_load_run();
    int n;
    logic [20:0] c0, c1, c2;
    c0 = {4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0001};
    c1 = {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
    c2 = {4'd0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'b0000};
    load(5'd0, mk(T_NEXT, 8'd0, c0));
    load(5'd1, mk(T_NEXT, 8'd0, c1));
    load(5'd2, mk(T_END, 8'd0, c2));
    sbq.push_back({2'b10, 21'd0});
    sbq.push_back({2'b10, c0});
    sbq.push_back({2'b10, c1});
    sbq.push_back({2'b01, c2});
    sbq.push_back({2'b00, 21'd0});
    pulse_start(5'd0);
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL load_run cycle%0d: got %h expected %h", n, obs(), e);
      end
      n++;
      if (sbq.size() != 0) step();
    end
  endtask

  task automatic test_jump_wrap();
    int n;
    logic [AW-1:0] sa[2];
    logic [AW-1:0] ta[2];
    load(5'd31, mk(T_NEXT, 8'd0, pat(5'd31)));
    load(5'd0,  mk(T_END,  8'd0, pat(5'd0)));
    load(5'd4,  mk(T_JUMP, 8'd7, pat(5'd4)));
    load(5'd5,  mk(T_END,  8'd0, pat(5'd5)));
    load(5'd7,  mk(T_END,  8'd0, pat(5'd7)));
    sa = '{5'd31, 5'd4};
    ta = '{5'd0, 5'd7};
    for (int k = 0; k < 2; k++) begin
      sbq.push_back({2'b10, 21'd0});
      sbq.push_back({2'b10, pat(sa[k])});
      sbq.push_back({2'b01, pat(ta[k])});
      sbq.push_back({2'b00, 21'd0});
      pulse_start(sa[k]);
      n = 0;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL jump_wrap run%0d cycle%0d: got %h expected %h", k, n, obs(), e);
        end
        n++;
        if (sbq.size() != 0) step();
      end
    end
  endtask

  task automatic test_branches();
    int n;
    logic [AW-1:0] sa[4];
    logic [AW-1:0] ta[4];
    logic [3:0]    ra[4];
    logic          pa[4];
    load(5'd8,  mk(T_BRZ, 8'd10, pat(5'd8)));
    load(5'd9,  mk(T_END, 8'd0,  pat(5'd9)));
    load(5'd10, mk(T_END, 8'd0,  pat(5'd10)));
    load(5'd11, mk(T_BRC, 8'd13, pat(5'd11)));
    load(5'd12, mk(T_END, 8'd0,  pat(5'd12)));
    load(5'd13, mk(T_END, 8'd0,  pat(5'd13)));
    sa = '{5'd8, 5'd8, 5'd11, 5'd11};
    ta = '{5'd10, 5'd9, 5'd13, 5'd12};
    ra = '{4'd0, 4'd5, 4'd5, 4'd0};
    pa = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      R = ra[k]; Pout = pa[k];
      sbq.push_back({2'b10, 21'd0});
      sbq.push_back({2'b10, pat(sa[k])});
      sbq.push_back({2'b01, pat(ta[k])});
      sbq.push_back({2'b00, 21'd0});
      pulse_start(sa[k]);
      n = 0;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL branch case%0d cycle%0d: got %h expected %h", k, n, obs(), e);
        end
        n++;
        if (sbq.size() != 0) step();
      end
    end
    R = 4'd0; Pout = 1'b0;
  endtask

  task automatic test_start_guard();
    int n;
    load(5'd14, mk(T_NEXT, 8'd0, pat(5'd14)));
    load(5'd15, mk(T_NEXT, 8'd0, pat(5'd15)));
    load(5'd16, mk(T_END,  8'd0, pat(5'd16)));
    load(5'd20, mk(T_END,  8'd0, pat(5'd20)));
    sbq.push_back({2'b10, 21'd0});
    sbq.push_back({2'b10, pat(5'd14)});
    sbq.push_back({2'b10, pat(5'd15)});
    sbq.push_back({2'b01, pat(5'd16)});
    sbq.push_back({2'b00, 21'd0});
    pulse_start(5'd14);
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL start_guard cycle%0d: got %h expected %h", n, obs(), e);
      end
      start = (n < 2); start_addr = 5'd20;
      n++;
      if (sbq.size() != 0) step();
    end
    start = 1'b0;
  endtask

  task automatic test_prog_guard();
    int n;
    load(5'd17, mk(T_NEXT, 8'd0, pat(5'd17)));
    load(5'd18, mk(T_END,  8'd0, pat(5'd18)));
    for (int k = 0; k < 2; k++) begin
      sbq.push_back({2'b10, 21'd0});
      sbq.push_back({2'b10, pat(5'd17)});
      sbq.push_back({2'b01, pat(5'd18)});
      sbq.push_back({2'b00, 21'd0});
      pulse_start(5'd17);
      n = 0;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL prog_guard run%0d cycle%0d: got %h expected %h", k, n, obs(), e);
        end
        // First run attempts to overwrite word 18 while RUN; the second run reads it back
        prog_we = (k == 0) && (n < 2);
        prog_addr = 5'd18;
        prog_data = mk(T_NEXT, 8'd0, 21'h1BAD0);
        n++;
        if (sbq.size() != 0) step();
      end
      prog_we = 1'b0;
    end
    load(5'd21, mk(T_END, 8'd0, 21'h0AAAA));
    sbq.push_back({2'b10, 21'd0});
    sbq.push_back({2'b01, 21'h15555});
    sbq.push_back({2'b00, 21'd0});
    prog_we = 1'b1; prog_addr = 5'd21; prog_data = mk(T_END, 8'd0, 21'h15555);
    pulse_start(5'd21);
    prog_we = 1'b0;
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL we_and_start cycle%0d: got %h expected %h", n, obs(), e);
      end
      n++;
      if (sbq.size() != 0) step();
    end
  endtask

  task automatic test_reset_midrun();
    load(5'd22, mk(T_NEXT, 8'd0, pat(5'd22)));
    load(5'd23, mk(T_NEXT, 8'd0, pat(5'd23)));
    load(5'd24, mk(T_NEXT, 8'd0, pat(5'd24)));
    load(5'd25, mk(T_END,  8'd0, pat(5'd25)));
    pulse_start(5'd22);
    step(); step();
    checks++;
    if (obs() !== {2'b10, pat(5'd23)}) begin
      errors++;
      $display("FAIL midrun_progress: got %h expected %h", obs(), {2'b10, pat(5'd23)});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 23'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs(), 23'd0);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs() !== 23'd0) begin
        errors++;
        $display("FAIL reset_no_done cycle%0d: got %h expected %h", k, obs(), 23'd0);
      end
      step();
    end
  endtask

  task automatic test_subroutine();
    int n;
    load(5'd3,  mk(T_CALL, 8'd20, pat(5'd3)));
    load(5'd4,  mk(T_END,  8'd0,  pat(5'd4)));
    load(5'd20, mk(T_RET,  8'd0,  pat(5'd20)));
    sbq.push_back({2'b10, 21'd0});
    sbq.push_back({2'b10, pat(5'd3)});
`ifdef SUBROUTINE_EN
    sbq.push_back({2'b10, pat(5'd20)});
`endif
    sbq.push_back({2'b01, pat(5'd4)});
    sbq.push_back({2'b00, 21'd0});
    pulse_start(5'd3);
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL call_ret cycle%0d: got %h expected %h", n, obs(), e);
      end
      n++;
      if (sbq.size() != 0) step();
    end
`ifdef SUBROUTINE_EN
    begin
      logic [AW-1:0] na[11];
      logic [2:0]    no[11];
      logic [7:0]    nt[11];
      // Five nested calls (fifth push dropped), five returns, last on an empty stack
      na = '{5'd22, 5'd25, 5'd28, 5'd30, 5'd16, 5'd18, 5'd31, 5'd29, 5'd26, 5'd23, 5'd24};
      no = '{T_CALL, T_CALL, T_CALL, T_CALL, T_CALL, T_RET, T_RET, T_RET, T_RET, T_RET, T_END};
      nt = '{8'd25, 8'd28, 8'd30, 8'd16, 8'd18, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      for (int k = 0; k < 11; k++) load(na[k], mk(no[k], nt[k], pat(na[k])));
      sbq.push_back({2'b10, 21'd0});
      for (int k = 0; k < 10; k++) sbq.push_back({2'b10, pat(na[k])});
      sbq.push_back({2'b01, pat(na[10])});
      sbq.push_back({2'b00, 21'd0});
      pulse_start(5'd22);
      n = 0;
      while (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL nested_calls cycle%0d: got %h expected %h", n, obs(), e);
        end
        n++;
        if (sbq.size() != 0) step();
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_jump_wrap();
    test_branches();
    test_start_guard();
    test_prog_guard();
    test_reset_midrun();
    test_subroutine();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
